// File: rtl/cbuf_pkg.sv
// cbuf_pkg: shared read-state encoding, default sizing and the wrap-around add
// used by both the read and write sides of the circular column buffer.
package cbuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } rd_state_e;

  localparam int unsigned CBUF_COLUMNS = 32;
  localparam int unsigned CBUF_PTR_W   = $clog2(CBUF_COLUMNS);
  localparam int unsigned CBUF_CNT_W   = CBUF_PTR_W + 1;

  // (a + b) mod cols, assuming both operands are already below cols
  function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                          input int unsigned cols);
    int unsigned sum;
    sum = a + b;
    if (sum >= cols) begin
      return sum - cols;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/cbuf_read_ctrl_ptr_wrap_add.sv
// ptr_wrap_add: pointer-width (a + b) mod COLUMNS; b must be below COLUMNS.
module ptr_wrap_add
  import cbuf_pkg::*;
#(
  parameter  int unsigned COLUMNS = 32,
  localparam int unsigned PTR_W   = $clog2(COLUMNS)
) (
  input  logic [PTR_W-1:0] i_a,
  input  logic [PTR_W-1:0] i_b,
  output logic [PTR_W-1:0] o_sum
);

  assign o_sum = PTR_W'(mod_add(32'(i_a), 32'(i_b), COLUMNS));

endmodule

// File: rtl/cbuf_read_ctrl.sv
// cbuf_read_ctrl: read side of the circular column buffer; pops PAR_READ entries per beat
// onto a valid/ready port. Define CBUF_RD_FLUSH_EN to add partial-group flush (flush/out_mask).
module cbuf_read_ctrl
  import cbuf_pkg::*;
#(
  parameter  int unsigned COLUMNS    = 32,
  parameter  int unsigned PAR_READ   = 4,
  parameter  int unsigned DATA_WIDTH = 16,
  localparam int unsigned PTR_W      = $clog2(COLUMNS),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PTR_W-1:0]               write_ptr,
  output logic [PTR_W-1:0]               read_ptr,
  output logic                           rd_en,
  output logic [PAR_READ*PTR_W-1:0]      rd_addr,
  input  logic [PAR_READ*DATA_WIDTH-1:0] rd_data,
  output logic                           out_valid,
  input  logic                           out_ready,
`ifdef CBUF_RD_FLUSH_EN
  input  logic                           flush,
  output logic [PAR_READ-1:0]            out_mask,
`endif
  output logic [PAR_READ*DATA_WIDTH-1:0] out_data
);

  localparam logic [CNT_W-1:0] COLS_C = CNT_W'(COLUMNS);
  localparam logic [CNT_W-1:0] PAR_C  = CNT_W'(PAR_READ);

  rd_state_e                     r_state, w_state_next;
  logic [PTR_W-1:0]              r_read_ptr, w_ptr_next, w_n;
  logic [CNT_W-1:0]              w_avail;
  logic                          w_issue, w_load, r_valid, w_valid_next;
  logic [PAR_READ-1:0]           r_pend_mask, w_mask_new;
  logic [PAR_READ*DATA_WIDTH-1:0] r_out_data, w_capture;

  // occupancy; the writer never fills the last slot, so WP==RP is unambiguously empty
  always_comb begin
    if (write_ptr >= r_read_ptr) begin
      w_avail = {1'b0, write_ptr} - {1'b0, r_read_ptr};
    end else begin
      w_avail = {1'b0, write_ptr} + COLS_C - {1'b0, r_read_ptr};
    end
  end

  // next state, issue decision and pop size
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_n          = PTR_W'(PAR_READ);
    w_mask_new   = '1;
    w_load       = 1'b0;
    w_valid_next = r_valid;
    case (r_state)
      ST_IDLE: begin
        if (w_avail >= PAR_C) begin
          w_issue      = 1'b1;
          w_state_next = ST_FETCH;
        end
`ifdef CBUF_RD_FLUSH_EN
        else if (flush && (w_avail != '0)) begin
          w_issue      = 1'b1;
          w_n          = w_avail[PTR_W-1:0];
          w_state_next = ST_FETCH;
          for (int i = 0; i < PAR_READ; i++) begin
            w_mask_new[i] = (CNT_W'(i) < w_avail);
          end
        end
`endif
        else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_FETCH: begin
        w_load       = 1'b1;
        w_valid_next = 1'b1;
        w_state_next = ST_VALID;
      end
      ST_VALID: begin
        if (out_ready) begin
          w_valid_next = 1'b0;
          if (w_avail >= PAR_C) begin
            w_issue      = 1'b1;
            w_state_next = ST_FETCH;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_state_next = ST_VALID;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_valid_next = 1'b0;
      end
    endcase
  end

  // lanes beyond a partial pop are forced to zero
  always_comb begin
    w_capture = '0;
    for (int i = 0; i < PAR_READ; i++) begin
      if (r_pend_mask[i]) begin
        w_capture[i*DATA_WIDTH +: DATA_WIDTH] = rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_capture[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  for (genvar g = 0; g < PAR_READ; g++) begin : g_lane
    ptr_wrap_add #(.COLUMNS(COLUMNS)) u_lane_add (
      .i_a  (r_read_ptr),
      .i_b  (PTR_W'(g)),
      .o_sum(rd_addr[g*PTR_W +: PTR_W])
    );
  end

  ptr_wrap_add #(.COLUMNS(COLUMNS)) u_ptr_adv (
    .i_a  (r_read_ptr),
    .i_b  (w_n),
    .o_sum(w_ptr_next)
  );

  // read_ptr moves in the issue cycle, after the memory has sampled the lane addresses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_read_ptr  <= '0;
      r_valid     <= 1'b0;
      r_out_data  <= '0;
      r_pend_mask <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_valid_next;
      if (w_issue) begin
        r_read_ptr  <= w_ptr_next;
        r_pend_mask <= w_mask_new;
      end
      if (w_load) begin
        r_out_data <= w_capture;
      end
    end
  end

`ifdef CBUF_RD_FLUSH_EN
  logic [PAR_READ-1:0] r_out_mask;

  // lane-valid mask travels with the captured group
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_mask <= '0;
    end else if (w_load) begin
      r_out_mask <= r_pend_mask;
    end
  end

  assign out_mask = r_out_mask;
`endif

  assign rd_en     = w_issue & ~rst;
  assign read_ptr  = r_read_ptr;
  assign out_valid = r_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_cbuf_read_ctrl.sv
// Bench for cbuf_read_ctrl: bench-side buffer memory and writer, queue-based reference model.
module tb_cbuf_read_ctrl;
  localparam int COLS = 32;
  localparam int PAR  = 4;
  localparam int DW   = 16;
  localparam int PW   = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PW-1:0]     write_ptr = 5'd0;
  logic [PW-1:0]     read_ptr;
  logic              rd_en;
  logic [PAR*PW-1:0] rd_addr;
  logic [PAR*DW-1:0] rd_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              flush = 1'b0;
  logic [PAR-1:0]    out_mask;
  logic [PAR*DW-1:0] out_data;

  cbuf_read_ctrl #(.COLUMNS(COLS), .PAR_READ(PAR), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .write_ptr(write_ptr), .read_ptr(read_ptr), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef CBUF_RD_FLUSH_EN
    .flush(flush), .out_mask(out_mask),
`endif
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0]     mem [COLS];
  logic [DW-1:0]     q[$];
  int                n_tests = 0;
  int                n_fail = 0;
  int                m_rp = 0;
  bit                m_pend = 1'b0;
  int                m_iss_cyc = 0;
  int                cyc = 0;
  logic [PAR*DW-1:0] m_group = '0;
  logic [PAR-1:0]    m_mask = '0;
  bit                chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 1-cycle synchronous-read buffer memory
  always @(posedge clk) begin
    if (rd_en) begin
      for (int i = 0; i < PAR; i++) rd_data[i*DW +: DW] <= mem[rd_addr[i*PW +: PW]];
    end
  end

  // reference model: a group is issued when the port is free and enough entries are queued,
  // and becomes visible two cycles after its issue; entries leave the queue in write order
  always @(negedge clk) begin
    bit exp_valid, accept, free;
    int n;
    if (chk_en) begin
      exp_valid = m_pend && (cyc - m_iss_cyc >= 2);
      accept    = exp_valid && out_ready;
      free      = !m_pend || accept;
      n = 0;
      if (free && q.size() >= PAR) n = PAR;
`ifdef CBUF_RD_FLUSH_EN
      else if (!m_pend && flush && q.size() > 0) n = q.size();
`endif
      check("read_ptr", 64'(read_ptr), 64'(m_rp));
      check("rd_en", 64'(rd_en), 64'(n != 0));
      check("out_valid", 64'(out_valid), 64'(exp_valid));
      for (int i = 0; i < PAR; i++)
        check("rd_addr", 64'(rd_addr[i*PW +: PW]), 64'((m_rp + i) % COLS));
      if (exp_valid) begin
        check("out_data", out_data, m_group);
`ifdef CBUF_RD_FLUSH_EN
        check("out_mask", 64'(out_mask), 64'(m_mask));
`endif
      end
      if (accept) m_pend = 1'b0;
      if (n != 0) begin
        m_group = '0;
        m_mask  = '0;
        for (int i = 0; i < n; i++) begin
          m_group[i*DW +: DW] = q.pop_front();
          m_mask[i] = 1'b1;
        end
        m_rp      = (m_rp + n) % COLS;
        m_pend    = 1'b1;
        m_iss_cyc = cyc;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write();
    if (5'(write_ptr + 5'd1) != read_ptr) begin
      mem[write_ptr] = 16'($urandom);
      q.push_back(mem[write_ptr]);
      write_ptr = write_ptr + 5'd1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [PAR*DW-1:0] snap_data;
    logic [PW-1:0] snap_rp;
    for (int i = 0; i < COLS; i++) mem[i] = 16'h0;
    for (int i = 0; i < 5; i++) begin
      mem[i] = 16'hA000 + 16'(i);
      q.push_back(mem[i]);
    end
    write_ptr = 5'd5;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset read_ptr", 64'(read_ptr), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset rd_en", 64'(rd_en), 64'd0);
    check("reset out_data", out_data, 64'd0);

    // release: issue in the first cycle, out_valid two cycles later
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("first issue", 64'(rd_en), 64'd1);
    check("first lane3 addr", 64'(rd_addr[3*PW +: PW]), 64'd3);
    @(negedge clk);
    check("fetch no valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("first valid", 64'(out_valid), 64'd1);
    check("first group", out_data, 64'hA003_A002_A001_A000);

    // one entry left: nothing may be popped
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_en) cnt++;
    end
    check("underfull no issue", 64'(cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      do_write();
    end
    @(negedge clk);
    check("avail4 issue", 64'(rd_en), 64'd1);
    check("avail4 lane0", 64'(rd_addr[0 +: PW]), 64'd4);
    check("avail4 lane3", 64'(rd_addr[3*PW +: PW]), 64'd7);

    // random traffic, many pointer wraps
    for (int i = 0; i < 2500; i++) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) != 0) do_write();
    end

    // fill to full behind a stalled group
    tick();
    out_ready = 1'b0;
    flush = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      do_write();
      if ((5'(write_ptr + 5'd1) == read_ptr) && out_valid) break;
    end
    check("full reached", 64'(5'(write_ptr - read_ptr)), 64'd31);
    check("stalled valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    snap_data = out_data;
    snap_rp = read_ptr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall data", out_data, snap_data);
      check("stall read_ptr", 64'(read_ptr), 64'(snap_rp));
    end
    tick();
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) check("ready issues at once", 64'(rd_en), 64'd1);
      if (rd_en) cnt++;
    end
    check("drain groups", 64'(cnt), 64'd7);
    check("drain leftover", 64'(5'(write_ptr - read_ptr)), 64'd3);
    check("drain idle", 64'(rd_en), 64'd0);

`ifdef CBUF_RD_FLUSH_EN
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("flush issue", 64'(rd_en), 64'd1);
    snap_rp = read_ptr;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("flush valid", 64'(out_valid), 64'd1);
    check("flush mask", 64'(out_mask), 64'h7);
    check("flush lane3", 64'(out_data[3*DW +: DW]), 64'd0);
    check("flush read_ptr", 64'(read_ptr), 64'(5'(snap_rp + 5'd3)));
`endif

    // get a group stalled in VALID, then reset asynchronously mid-cycle
    tick();
    out_ready = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      tick();
      do_write();
    end
    check("pre-reset valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    #2;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async rst out_valid", 64'(out_valid), 64'd0);
    check("async rst read_ptr", 64'(read_ptr), 64'd0);
    check("async rst rd_en", 64'(rd_en), 64'd0);
    check("async rst out_data", out_data, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
